// File: rtl/ltc2308_emulator.sv
// LTC2308 responder model: answers the ADC interface master on CONVST/SCK/SDI/SDO.
// All pins are oversampled on clk; nothing runs on ADC_SCK.
// Optional build macro LTC_EMU_DITHER_EN adds LFSR dither (+1/0/-1) to latched samples.
module ltc2308_emulator #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CONV_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ADC_CONVST,
  input  logic                ADC_SCK,
  input  logic                ADC_SDI,
  output logic                ADC_SDO,
  input  logic [8*DATA_W-1:0] sample_data,
  input  logic                err_clr,
  output logic                busy,
  output logic [5:0]          cfg_word,
  output logic                cfg_valid,
  output logic [15:0]         frame_count,
  output logic                proto_err
);

  localparam int unsigned TW = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StConv, StShift} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  convst_sync, sck_sync, sdi_sync;
  logic                    convst_prev, sck_prev;
  logic                    convst_rise, sck_rise, sck_fall, sdi_s;
  logic [TW-1:0]           timer_q;
  logic [5:0]              cfg_sr_q, cfg_eff;
  logic [2:0]              cfg_cnt_q;
  logic [DATA_W-1:0]       sr_q, result_q, result;
  logic                    accept, expire, err_set;
  logic [DATA_W-1:0]       samp [8];
  logic [2:0]              ch_a, ch_b;
  logic [DATA_W-1:0]       va, vb, sa, sb;
  logic [DATA_W:0]         diff;

  // Pin synchronizers plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync <= '0;
      sck_sync    <= '0;
      sdi_sync    <= '0;
      convst_prev <= 1'b0;
      sck_prev    <= 1'b0;
    end else begin
      convst_sync <= {convst_sync[SYNC_STAGES-2:0], ADC_CONVST};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], ADC_SCK};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], ADC_SDI};
      convst_prev <= convst_sync[SYNC_STAGES-1];
      sck_prev    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign convst_rise = convst_sync[SYNC_STAGES-1] & ~convst_prev;
  assign sck_rise    = sck_sync[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall    = ~sck_sync[SYNC_STAGES-1] & sck_prev;
  assign sdi_s       = sdi_sync[SYNC_STAGES-1];

  // Config used by a conversion accepted this cycle: freshly shifted word if complete
  assign cfg_eff = (cfg_cnt_q == 3'd6) ? cfg_sr_q : cfg_word;
  assign ch_a    = {cfg_eff[3], cfg_eff[2], cfg_eff[4]};
  assign ch_b    = {cfg_eff[3], cfg_eff[2], ~cfg_eff[4]};

  // Unpack the flat sample bus into per-channel words
  always_comb begin
    for (int i = 0; i < 8; i++) samp[i] = sample_data[i*DATA_W +: DATA_W];
  end

  assign va = samp[ch_a];
  assign vb = samp[ch_b];

`ifdef LTC_EMU_DITHER_EN
  logic [15:0] lfsr_q;

  function automatic logic [DATA_W-1:0] add_dither(input logic [DATA_W-1:0] v,
                                                   input logic [1:0] d);
    if (d == 2'b01) return (v == 12'hFFF) ? v : v + 12'd1;
    if (d == 2'b10) return (v == 12'h000) ? v : v - 12'd1;
    return v;
  endfunction

  assign sa = add_dither(va, lfsr_q[1:0]);
  assign sb = add_dither(vb, lfsr_q[1:0]);

  // Fibonacci LFSR (taps 16,14,13,11) stepped once per accepted conversion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else if (accept) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`else
  assign sa = va;
  assign sb = vb;
`endif

  // Conversion result from the selected sample(s) and mode bits
  always_comb begin
    diff   = {1'b0, sa} - {1'b0, sb};
    result = '0;
    if (cfg_eff[5]) begin
      result = cfg_eff[1] ? sa : (sa ^ 12'h800);
    end else if (cfg_eff[1]) begin
      result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
    end else if (!diff[DATA_W] && diff[DATA_W-1]) begin
      result = 12'h7FF;
    end else if (diff[DATA_W] && !diff[DATA_W-1]) begin
      result = 12'h800;
    end else begin
      result = diff[DATA_W-1:0];
    end
  end

  // Next-state decode and protocol error detection
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    expire  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (convst_rise) begin
          accept  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        if (convst_rise || sck_rise || sck_fall) err_set = 1'b1;
        if (timer_q == '0) begin
          expire  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (convst_rise) begin
          accept  = 1'b1;
          state_d = StConv;
          if (cfg_cnt_q != 3'd6) err_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, conversion timer, config capture and output shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      busy        <= 1'b0;
      cfg_word    <= 6'b100010;
      cfg_valid   <= 1'b0;
      cfg_sr_q    <= '0;
      cfg_cnt_q   <= '0;
      frame_count <= '0;
      proto_err   <= 1'b0;
      result_q    <= '0;
      sr_q        <= '0;
      ADC_SDO     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_valid <= 1'b0;
      if (accept) begin
        if (cfg_cnt_q == 3'd6) begin
          cfg_word  <= cfg_sr_q;
          cfg_valid <= 1'b1;
        end
        result_q    <= result;
        busy        <= 1'b1;
        timer_q     <= TW'(CONV_CYCLES - 1);
        frame_count <= frame_count + 16'd1;
        cfg_sr_q    <= '0;
        cfg_cnt_q   <= '0;
        sr_q        <= '0;
      end else if (state_q == StConv) begin
        if (expire) begin
          busy <= 1'b0;
          sr_q <= result_q;
        end else begin
          timer_q <= timer_q - TW'(1);
        end
      end else if (state_q == StShift) begin
        // Zero fill makes SDO read 0 after the 12th fall
        if (sck_fall) sr_q <= {sr_q[DATA_W-2:0], 1'b0};
        if (sck_rise && cfg_cnt_q < 3'd6) begin
          cfg_sr_q  <= {cfg_sr_q[4:0], sdi_s};
          cfg_cnt_q <= cfg_cnt_q + 3'd1;
        end
      end
      ADC_SDO   <= (state_q == StShift) ? sr_q[DATA_W-1] : 1'b0;
      // A new error outranks a simultaneous clear
      proto_err <= err_set | (proto_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed bench for ltc2308_emulator acting as the ADC master.
module tb_ltc2308_emulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        convst = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [95:0] sample_data = '0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic [5:0]  cfg_word;
  logic        cfg_valid;
  logic [15:0] frame_count;
  logic        proto_err;

  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          busy_cycles;
  int          valid_pulses;
  logic        timed_out;
  logic [11:0] rd;
  logic        extra;

  always #5 clk = ~clk;

  ltc2308_emulator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ADC_CONVST (convst),
    .ADC_SCK    (sck),
    .ADC_SDI    (sdi),
    .ADC_SDO    (sdo),
    .sample_data(sample_data),
    .err_clr    (err_clr),
    .busy       (busy),
    .cfg_word   (cfg_word),
    .cfg_valid  (cfg_valid),
    .frame_count(frame_count),
    .proto_err  (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    sample_data[n*12 +: 12] = v;
  endtask

  // CONVST pulse, then measure busy width; optional second CONVST mid-conversion
  task automatic start_conv(input bit glitch);
    busy_cycles  = 0;
    valid_pulses = 0;
    timed_out    = 1'b1;
    convst       = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 2) convst = 1'b0;
      if (glitch && i == 20) convst = 1'b1;
      if (glitch && i == 24) convst = 1'b0;
      if (cfg_valid) valid_pulses++;
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("conv_done_in_time", {31'd0, timed_out}, 32'd0);
  endtask

  // nbits SCK cycles: SDO read before each rise, cfg shifted MSB first on SDI
  task automatic frame(input logic [5:0] cfg, input int nbits);
    rd    = '0;
    extra = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      sdi = (b < 6) ? cfg[5-b] : 1'b0;
      repeat (8) @(negedge clk);
      if (b < 12) rd = {rd[10:0], sdo};
      else extra = extra | sdo;
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
    sdi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sdo", {31'd0, sdo}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_word", {26'd0, cfg_word}, 32'h22);
    check("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);

    // Frame 1: default config reads ch0; shift in CH1 single-ended unipolar
    set_ch(0, 12'hA5C);
    start_conv(1'b0);
    check("f1_busy_width", busy_cycles, 32'd64);
    check("f1_frame_count", {16'd0, frame_count}, 32'd1);
    check("f1_no_cfg_valid", valid_pulses, 32'd0);
    frame(6'b110010, 12);
    check("f1_readout", {20'd0, rd}, 32'hA5C);

    // Frame 2: new config takes effect
    set_ch(1, 12'h123);
    start_conv(1'b0);
    check("f2_cfg_valid", valid_pulses, 32'd1);
    check("f2_cfg_word", {26'd0, cfg_word}, 32'h32);
    check("f2_frame_count", {16'd0, frame_count}, 32'd2);
    frame(6'b101000, 12);
    check("f2_readout", {20'd0, rd}, 32'h123);

    // Frames 3-4: single-ended bipolar, channel {S1,S0,OS}=100
    set_ch(2, 12'h7FF);
    set_ch(4, 12'h7FF);
    start_conv(1'b0);
    check("f3_cfg_word", {26'd0, cfg_word}, 32'h28);
    frame(6'b101000, 12);
    check("f3_bipolar_max", {20'd0, rd}, 32'hFFF);
    set_ch(2, 12'h000);
    set_ch(4, 12'h000);
    start_conv(1'b0);
    check("f4_frame_count", {16'd0, frame_count}, 32'd4);
    frame(6'b000010, 12);
    check("f4_bipolar_zero", {20'd0, rd}, 32'h800);

    // Frames 5-7: differential
    set_ch(0, 12'h100);
    set_ch(1, 12'h300);
    start_conv(1'b0);
    frame(6'b010010, 12);
    check("f5_diff_uni_neg", {20'd0, rd}, 32'h000);
    start_conv(1'b0);
    frame(6'b000000, 12);
    check("f6_diff_uni_pos", {20'd0, rd}, 32'h200);
    set_ch(0, 12'hFFF);
    set_ch(1, 12'h000);
    start_conv(1'b0);
    check("f7_frame_count", {16'd0, frame_count}, 32'd7);
    frame(6'b100010, 12);
    check("f7_diff_bip_clamp", {20'd0, rd}, 32'h7FF);
    check("f7_no_proto_err", {31'd0, proto_err}, 32'd0);

    // Frame 8: CONVST during conversion, then 14 SCK cycles
    set_ch(0, 12'h5A3);
    start_conv(1'b1);
    check("f8_glitch_err", {31'd0, proto_err}, 32'd1);
    check("f8_frame_count", {16'd0, frame_count}, 32'd8);
    check("f8_busy_width", busy_cycles, 32'd64);
    frame(6'b100010, 14);
    check("f8_readout", {20'd0, rd}, 32'h5A3);
    check("f8_tail_zero", {31'd0, extra}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", {31'd0, proto_err}, 32'd0);

    // Frame 9: reset after 5 bits
    set_ch(0, 12'hFFF);
    set_ch(1, 12'h111);
    start_conv(1'b0);
    frame(6'b011111, 5);
    check("f9_sdo_before_reset", {31'd0, sdo}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sdo", {31'd0, sdo}, 32'd0);
    check("mid_rst_cfg_word", {26'd0, cfg_word}, 32'h22);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // First frame after reset starts from IDLE: no error, no cfg update, ch0
    set_ch(0, 12'h3C6);
    start_conv(1'b0);
    check("post_rst_no_err", {31'd0, proto_err}, 32'd0);
    check("post_rst_no_valid", valid_pulses, 32'd0);
    check("post_rst_frame_count", {16'd0, frame_count}, 32'd1);
    frame(6'b100010, 12);
    check("post_rst_readout", {20'd0, rd}, 32'h3C6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
